// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - execute-stage branch/jump resolution with bimodal predictor
//
// Resolves RV32 conditional branches, JAL and JALR one cycle after the request.
// It also trains a table of 2-bit saturating counters that fetch reads
// combinationally through the lookup port.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   lookup_pc        fetch PC; lookup_taken is the MSB of its counter (combinational)
//   valid_i          qualifies instr/pc/a/b/pred_taken_i for resolution
//   instr, pc        instruction word and its PC
//   a, b             rs1 / rs2 operand values
//   pred_taken_i     prediction that fetch acted on for this instruction
//   valid_o          registered: a resolve result is presented
//   br               registered actual taken decision
//   target           registered taken target (held while valid_i is low)
//   link             registered pc+4 (held while valid_i is low)
//   redirect         registered: fetch must restart at redirect_pc
//   redirect_pc      registered restart address (held while valid_i is low)
//   mispredict_cnt   saturating count of registered redirects

module branch_resolve #(
  parameter int BITS        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_BITS    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BITS-1:0]     lookup_pc,
  output logic                lookup_taken,
  input  logic                valid_i,
  input  logic [31:0]         instr,
  input  logic [BITS-1:0]     pc,
  input  logic [BITS-1:0]     a,
  input  logic [BITS-1:0]     b,
  input  logic                pred_taken_i,
  output logic                valid_o,
  output logic                br,
  output logic [BITS-1:0]     target,
  output logic [BITS-1:0]     link,
  output logic                redirect,
  output logic [BITS-1:0]     redirect_pc,
  output logic [CNT_BITS-1:0] mispredict_cnt
);

  localparam int IDX = $clog2(BHT_ENTRIES);
  // Immediates are built at least 32 bits wide so the J-immediate always fits,
  // then cut to the datapath width.
  localparam int EW  = (BITS > 32) ? BITS : 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    K_NONE,
    K_BRANCH,
    K_JAL,
    K_JALR
  } kind_e;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  kind_e      kind;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    kind = K_NONE;
    case (opcode)
      OP_BRANCH: if (funct3 != 3'b010 && funct3 != 3'b011) kind = K_BRANCH;
      OP_JAL:    kind = K_JAL;
      OP_JALR:   if (funct3 == 3'b000) kind = K_JALR;
      default:   kind = K_NONE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Immediates
  // ---------------------------------------------------------------------------
  logic [EW-1:0]   imm_b_ext;
  logic [EW-1:0]   imm_j_ext;
  logic [EW-1:0]   imm_i_ext;
  logic [BITS-1:0] imm_b;
  logic [BITS-1:0] imm_j;
  logic [BITS-1:0] imm_i;

  assign imm_b_ext = {{(EW-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
  assign imm_j_ext = {{(EW-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
  assign imm_i_ext = {{(EW-12){instr[31]}}, instr[31:20]};

  assign imm_b = imm_b_ext[BITS-1:0];
  assign imm_j = imm_j_ext[BITS-1:0];
  assign imm_i = imm_i_ext[BITS-1:0];

  // ---------------------------------------------------------------------------
  // Comparison and taken decision
  // ---------------------------------------------------------------------------
  logic eq;
  logic lt_s;
  logic lt_u;
  logic cond;
  logic taken_c;

  assign eq   = (a == b);
  assign lt_s = ($signed(a) < $signed(b));
  assign lt_u = (a < b);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = !lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = !lt_u;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    taken_c = 1'b0;
    case (kind)
      K_BRANCH: taken_c = cond;
      K_JAL:    taken_c = 1'b1;
      K_JALR:   taken_c = 1'b1;
      default:  taken_c = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Addresses (all sums wrap modulo 2^BITS)
  // ---------------------------------------------------------------------------
  logic [BITS-1:0] pc_plus4;
  logic [BITS-1:0] jalr_sum;
  logic [BITS-1:0] pc_rel_target;
  logic [BITS-1:0] target_c;
  logic [BITS-1:0] redirect_pc_c;

  assign pc_plus4      = pc + {{(BITS-3){1'b0}}, 3'b100};
  assign jalr_sum      = a + imm_i;
  assign pc_rel_target = pc + ((kind == K_JAL) ? imm_j : imm_b);
  assign target_c      = (kind == K_JALR) ? {jalr_sum[BITS-1:1], 1'b0} : pc_rel_target;
  assign redirect_pc_c = taken_c ? target_c : pc_plus4;

  // ---------------------------------------------------------------------------
  // Redirect: fetch went the wrong way, or cannot know a JALR target at all
  // ---------------------------------------------------------------------------
  logic redirect_c;

  always_comb begin
    redirect_c = 1'b0;
    if (valid_i) begin
      case (kind)
        K_BRANCH: redirect_c = (taken_c != pred_taken_i);
        K_JAL:    redirect_c = !pred_taken_i;
        K_JALR:   redirect_c = 1'b1;
        default:  redirect_c = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o        <= 1'b0;
      br             <= 1'b0;
      redirect       <= 1'b0;
      target         <= '0;
      link           <= '0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
    end else begin
      valid_o  <= valid_i;
      br       <= valid_i & taken_c;
      redirect <= redirect_c;
      // Address outputs keep their last resolved value through idle cycles.
      if (valid_i) begin
        target      <= target_c;
        link        <= pc_plus4;
        redirect_pc <= redirect_pc_c;
      end
      if (redirect_c && (mispredict_cnt != {CNT_BITS{1'b1}})) begin
        mispredict_cnt <= mispredict_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bimodal predictor table
  // ---------------------------------------------------------------------------
  logic [1:0]     bht [BHT_ENTRIES];
  logic [IDX-1:0] upd_idx;
  logic [IDX-1:0] look_idx;
  logic [1:0]     upd_cur;
  logic [1:0]     upd_next;
  logic           train;

  assign upd_idx  = pc[IDX+1:2];
  assign look_idx = lookup_pc[IDX+1:2];
  assign upd_cur  = bht[upd_idx];
  assign train    = valid_i && (kind == K_BRANCH);

  always_comb begin
    upd_next = upd_cur;
    if (taken_c) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (train) begin
      bht[upd_idx] <= upd_next;
    end
  end

  // Reads the table state before this cycle's training write lands.
  assign lookup_taken = bht[look_idx][1];

  logic unused_bits;
  assign unused_bits = ^{lookup_pc[BITS-1:IDX+2], lookup_pc[1:0], jalr_sum[0]};

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard bench for branch_resolve
module tb_branch_resolve;
  localparam int BITS = 32;
  localparam int BHT  = 16;
  localparam int CNTB = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [BITS-1:0] lookup_pc;
  logic            lookup_taken;
  logic            valid_i;
  logic [31:0]     instr;
  logic [BITS-1:0] pc, a, b;
  logic            pred_taken_i;
  logic            valid_o, br, redirect;
  logic [BITS-1:0] target, link, redirect_pc;
  logic [CNTB-1:0] mispredict_cnt;

  branch_resolve #(.BITS(BITS), .BHT_ENTRIES(BHT), .CNT_BITS(CNTB)) dut (
    .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .valid_i(valid_i), .instr(instr), .pc(pc), .a(a), .b(b),
    .pred_taken_i(pred_taken_i), .valid_o(valid_o), .br(br), .target(target),
    .link(link), .redirect(redirect), .redirect_pc(redirect_pc),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        br;
    logic        redirect;
    logic        tknown;
    logic [31:0] target;
    logic [31:0] link;
    logic [31:0] rpc;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_bht[BHT];
  int   m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < BHT; k++) m_bht[k] = 1;
    m_cnt = 0;
  endtask

  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [2:0] f3);
    return {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] im);
    return {im[20], im[10:1], im[11], im[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {im, 5'd1, f3, 5'd1, op};
  endfunction

  // Drive one request, check the combinational lookup against the model's
  // current table, then fold the request into the model and queue the result.
  task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] aa, input logic [31:0] bb, input logic pr,
                      input logic [31:0] lp);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        is_b, is_jal, is_jalr, tk, rd;
    logic [31:0] imm_b, imm_j, imm_i, tgt;
    int          idx;
    exp_t        e;
    @(posedge clk);
    #1;
    valid_i = v; instr = i; pc = p; a = aa; b = bb; pred_taken_i = pr; lookup_pc = lp;
    #1;
    chk("lookup_taken", {31'd0, lookup_taken}, (m_bht[(lp >> 2) % BHT] >= 2) ? 32'd1 : 32'd0);
    if (v) begin
      op      = i[6:0];
      f3      = i[14:12];
      is_b    = (op == 7'h63) && (f3 != 3'd2) && (f3 != 3'd3);
      is_jal  = (op == 7'h6f);
      is_jalr = (op == 7'h67) && (f3 == 3'd0);
      imm_b   = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      imm_j   = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      imm_i   = {{20{i[31]}}, i[31:20]};
      tk = 1'b0;
      if (is_b) begin
        case (f3)
          3'd0: tk = (aa == bb);
          3'd1: tk = (aa != bb);
          3'd4: tk = ($signed(aa) < $signed(bb));
          3'd5: tk = ($signed(aa) >= $signed(bb));
          3'd6: tk = (aa < bb);
          default: tk = (aa >= bb);
        endcase
      end else if (is_jal || is_jalr) begin
        tk = 1'b1;
      end
      tgt = is_jalr ? ((aa + imm_i) & ~32'd1) : (p + (is_jal ? imm_j : imm_b));
      rd  = is_b ? (tk != pr) : is_jal ? !pr : is_jalr;
      if (is_b) begin
        idx = (p >> 2) % BHT;
        m_bht[idx] = tk ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                        : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
      end
      if (rd && m_cnt < 65535) m_cnt++;
      e.br       = tk;
      e.redirect = rd;
      e.tknown   = is_b || is_jal || is_jalr;
      e.target   = tgt;
      e.link     = p + 32'd4;
      e.rpc      = tk ? tgt : p + 32'd4;
      e.cnt      = 16'(m_cnt);
      sb.push_back(e);
    end
  endtask

  task automatic rand_step();
    logic [31:0] r, i, p, aa, bb, lp;
    logic [2:0]  f3;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    f3  = 3'($urandom_range(0, 7));
    case (sel)
      5:       i = {r[31:7], 7'h6f};
      6:       i = {r[31:15], (($urandom_range(0, 3) == 0) ? 3'd1 : 3'd0), r[11:7], 7'h67};
      7:       i = r;
      default: i = {r[31:15], f3, r[11:7], 7'h63};
    endcase
    p = $urandom;
    if ($urandom_range(0, 1) == 1) p = p & 32'h3c;
    lp = ($urandom_range(0, 2) == 0) ? p : $urandom;
    aa = $urandom;
    bb = ($urandom_range(0, 2) == 0) ? aa : $urandom;
    if ($urandom_range(0, 3) == 0) begin
      aa = 32'($urandom_range(0, 3)) - 32'd1;
      bb = 32'($urandom_range(0, 3)) - 32'd1;
    end
    step($urandom_range(0, 4) != 0, i, p, aa, bb, 1'($urandom_range(0, 1)), lp);
  endtask

  task automatic check_cleared();
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_br", {31'd0, br}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_target", target, 32'd0);
    chk("rst_link", link, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_cnt", {16'd0, mispredict_cnt}, 32'd0);
    for (int k = 0; k < BHT; k++) begin
      lookup_pc = 32'(k) << 2;
      #1;
      chk("rst_lookup", {31'd0, lookup_taken}, 32'd0);
    end
  endtask

  // Monitor: registered outputs sampled on the falling edge.
  exp_t        me;
  logic [31:0] l_tgt, l_link, l_rpc;
  logic        l_tk;
  logic [15:0] l_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      l_tgt = 0; l_link = 0; l_rpc = 0; l_cnt = 0; l_tk = 1'b1;
    end else if (valid_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid_o: got 1 expected 0 at %0t", $time);
      end else begin
        me = sb.pop_front();
        chk("br", {31'd0, br}, {31'd0, me.br});
        chk("redirect", {31'd0, redirect}, {31'd0, me.redirect});
        chk("link", link, me.link);
        chk("redirect_pc", redirect_pc, me.rpc);
        chk("mispredict_cnt", {16'd0, mispredict_cnt}, {16'd0, me.cnt});
        if (me.tknown) chk("target", target, me.target);
        l_tgt = me.target; l_link = me.link; l_rpc = me.rpc; l_cnt = me.cnt; l_tk = me.tknown;
      end
    end else begin
      chk("idle_br", {31'd0, br}, 32'd0);
      chk("idle_redirect", {31'd0, redirect}, 32'd0);
      chk("idle_link", link, l_link);
      chk("idle_redirect_pc", redirect_pc, l_rpc);
      chk("idle_cnt", {16'd0, mispredict_cnt}, {16'd0, l_cnt});
      if (l_tk) chk("idle_target", target, l_tgt);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; instr = 0; pc = 0; a = 0; b = 0;
    pred_taken_i = 1'b0; lookup_pc = 0;
    model_reset();
    #3;
    check_cleared();
    @(posedge clk); #1 rst_n = 1'b1;

    // BEQ taken, mispredicted; same-cycle lookup sees the old counter.
    step(1, enc_b(13'd16, 3'd0), 32'h100, 32'd5, 32'd5, 1'b0, 32'h100);
    step(0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 32'h100);
    // Signed versus unsigned compares.
    step(1, enc_b(13'd32, 3'd4), 32'h200, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h200);
    step(1, enc_b(13'd32, 3'd6), 32'h204, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h204);
    step(1, enc_b(13'd32, 3'd5), 32'h208, 32'hFFFFFFFF, 32'd1, 1'b1, 32'h208);
    step(1, enc_b(13'd32, 3'd7), 32'h20c, 32'hFFFFFFFF, 32'd1, 1'b1, 32'h20c);
    // JALR always redirects, bit 0 of the target cleared.
    step(1, enc_i(12'd4, 3'd0, 7'h67), 32'h40, 32'h2003, 32'd0, 1'b1, 32'h40);
    step(0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 32'h8);
    // Saturation: five taken BNE, then one not taken.
    for (int k = 0; k < 5; k++)
      step(1, enc_b(13'h1ff0, 3'd1), 32'h8, 32'd1, 32'd2, 1'b1, 32'h8);
    step(1, enc_b(13'h1ff0, 3'd1), 32'h8, 32'd3, 32'd3, 1'b1, 32'h8);
    step(0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 32'h8);
    // Wrap-around JAL and a non-control funct3 under the branch opcode.
    step(1, enc_j(21'd8), 32'hFFFFFFFC, 32'd0, 32'd0, 1'b1, 32'h0);
    step(1, enc_b(13'd16, 3'd2), 32'h100, 32'd5, 32'd5, 1'b0, 32'h100);
    step(0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 32'h100);

    for (int n = 0; n < 1500; n++) rand_step();

    // Reset asserted in the middle of traffic.
    @(posedge clk); #1;
    valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_cleared();
    @(posedge clk); #1 rst_n = 1'b1;

    for (int n = 0; n < 1500; n++) rand_step();

    for (int n = 0; n < 3; n++) step(0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
